// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : multicycle_ctrl_if                                           |
// | Description : Fetch handshake, datapath control and data-memory strobes   |
// |               seen by the multi-cycle control unit.                       |
// |               master = controller view, slave = fetch/datapath/memory.    |
// | Revision    : 1.0  initial release                                        |
// +----------------------------------------------------------------------------+
interface multicycle_ctrl_if #(
   parameter int INSTR_W  = 9,
   parameter int ALU_OP_W = 3
);
   logic                instr_valid;
   logic                instr_ready;
   logic [INSTR_W-1:0]  instr;
   logic                zero_flag;
   logic                mem_ack;
   logic [ALU_OP_W-1:0] alu_op;
   logic                reg_write;
   logic                mem_read;
   logic                mem_write;
   logic                branch_taken;
   logic                pc_en;
   logic                illegal;
   logic                mem_err;

   modport master (
      input  instr_valid, instr, zero_flag, mem_ack,
      output instr_ready, alu_op, reg_write, mem_read, mem_write,
             branch_taken, pc_en, illegal, mem_err
   );

   modport slave (
      output instr_valid, instr, zero_flag, mem_ack,
      input  instr_ready, alu_op, reg_write, mem_read, mem_write,
             branch_taken, pc_en, illegal, mem_err
   );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : multicycle_ctrl                                              |
// | Description : Multi-cycle control unit for the 9-bit ISA. Latches one      |
// |               instruction per valid/ready handshake into IR and walks      |
// |               IDLE -> DECODE -> EXEC [-> MEM [-> WB]] -> IDLE, driving     |
// |               ALU, register-file, memory and PC control. MEM waits on      |
// |               mem_ack with a bounded timeout.                              |
// |               Optional: CTRL_PERF_CNT_EN adds retired_cnt and stall_cnt.   |
// | Revision    : 1.0  initial release                                        |
// +----------------------------------------------------------------------------+
module multicycle_ctrl #(
   parameter int INSTR_W     = 9,
   parameter int OPC_W       = 3,
   parameter int ALU_OP_W    = 3,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic                clk,
   input  logic                reset_n,
   multicycle_ctrl_if.master   bus
`ifdef CTRL_PERF_CNT_EN
   ,
   output logic [31:0]         retired_cnt,
   output logic [31:0]         stall_cnt
`endif
);

   // Wait counter only has to reach MEM_TIMEOUT-1.
   localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [INSTR_W-1:0]  ir_q, ir_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic [OPC_W-1:0]    w_opc;
   logic [OPC_W:0]      w_opc_ext;
   logic [2:0]          w_op3;
   logic                w_opc_illegal;
   logic                w_unused_ir;

   logic                w_instr_ready;
   logic [ALU_OP_W-1:0] w_alu_op;
   logic                w_reg_write;
   logic                w_mem_read;
   logic                w_mem_write;
   logic                w_branch_taken;
   logic                w_pc_en;
   logic                w_illegal;
   logic                w_mem_err;

   // Opcode fields come from the latched IR only, never from the live instr bus.
   // Any set bit at position 3 or above makes the opcode >= 8 (illegal); the
   // extra MSB keeps the slice valid when OPC_W is exactly 3.
   assign w_opc         = ir_q[INSTR_W-1 -: OPC_W];
   assign w_opc_ext     = {1'b0, w_opc};
   assign w_opc_illegal = |w_opc_ext[OPC_W:3];
   assign w_op3         = w_opc[2:0];
   // Operand bits are for the datapath, not for control decode.
   assign w_unused_ir   = ^ir_q;

   // State, IR and wait-counter registers; reset wins over every other event.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         ir_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state and control decode from state + IR (+ zero_flag/mem_ack where sampled).
   always_comb begin
      state_d        = state_q;
      ir_d           = ir_q;
      cnt_d          = cnt_q;
      w_instr_ready  = 1'b0;
      w_alu_op       = '0;
      w_reg_write    = 1'b0;
      w_mem_read     = 1'b0;
      w_mem_write    = 1'b0;
      w_branch_taken = 1'b0;
      w_pc_en        = 1'b0;
      w_illegal      = 1'b0;
      w_mem_err      = 1'b0;

      case (state_q)
         S_IDLE: begin
            w_instr_ready = 1'b1;
            if (bus.instr_valid) begin
               ir_d    = bus.instr;
               state_d = S_DECODE;
            end
         end

         S_DECODE: begin
            state_d = S_EXEC;
         end

         S_EXEC: begin
            state_d = S_IDLE;
            if (w_opc_illegal) begin
               // Retired as a NOP: PC advances, nothing else fires.
               w_illegal = 1'b1;
               w_pc_en   = 1'b1;
            end else begin
               case (w_op3)
                  3'd0, 3'd1, 3'd2, 3'd3: begin
                     w_alu_op    = ALU_OP_W'(w_op3[1:0]);
                     w_reg_write = 1'b1;
                     w_pc_en     = 1'b1;
                  end
                  3'd4, 3'd5: begin
                     cnt_d   = '0;
                     state_d = S_MEM;
                  end
                  3'd6: begin
                     w_branch_taken = 1'b1;
                     w_pc_en        = 1'b1;
                  end
                  default: begin
                     w_branch_taken = bus.zero_flag;
                     w_pc_en        = 1'b1;
                  end
               endcase
            end
         end

         S_MEM: begin
            // Request stays asserted for every MEM cycle, including the ack
            // cycle and the timeout cycle; op3[0] distinguishes LDR/STR.
            w_mem_read  = ~w_op3[0];
            w_mem_write = w_op3[0];
            if (bus.mem_ack) begin
               cnt_d = '0;
               if (w_op3[0]) begin
                  w_pc_en = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  state_d = S_WB;
               end
            end else if (cnt_q == C_CNT_LAST) begin
               w_mem_err = 1'b1;
               w_pc_en   = 1'b1;
               cnt_d     = '0;
               state_d   = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         S_WB: begin
            w_reg_write = 1'b1;
            w_pc_en     = 1'b1;
            state_d     = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.instr_ready  = w_instr_ready;
   assign bus.alu_op       = w_alu_op;
   assign bus.reg_write    = w_reg_write;
   assign bus.mem_read     = w_mem_read;
   assign bus.mem_write    = w_mem_write;
   assign bus.branch_taken = w_branch_taken;
   assign bus.pc_en        = w_pc_en;
   assign bus.illegal      = w_illegal;
   assign bus.mem_err      = w_mem_err;

`ifdef CTRL_PERF_CNT_EN
   logic [31:0] retired_cnt_q;
   logic [31:0] stall_cnt_q;

   // Free-running wrap-around counters of retires and unacknowledged MEM cycles.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         retired_cnt_q <= '0;
         stall_cnt_q   <= '0;
      end else begin
         if (w_pc_en) begin
            retired_cnt_q <= retired_cnt_q + 32'd1;
         end
         if ((state_q == S_MEM) && !bus.mem_ack) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
      end
   end

   assign retired_cnt = retired_cnt_q;
   assign stall_cnt   = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_multicycle_ctrl                                           |
// | Description : Scoreboard bench for multicycle_ctrl (OPC_W=4, MEM_TIMEOUT=4)|
// | Revision    : 1.0  initial release                                        |
// +----------------------------------------------------------------------------+
module tb_multicycle_ctrl;

   localparam int IW = 10;
   localparam int OW = 4;
   localparam int AW = 3;
   localparam int TO = 4;

   // Observed vector: {ready, alu_op[2:0], rw, mr, mw, bt, pc, il, me}
   localparam logic [10:0] E_IDLE   = 11'b1_000_0000000;
   localparam logic [10:0] E_NONE   = 11'b0_000_0000000;
   localparam logic [10:0] E_ALU1   = 11'b0_001_1000100;
   localparam logic [10:0] E_ALU3   = 11'b0_011_1000100;
   localparam logic [10:0] E_MR     = 11'b0_000_0100000;
   localparam logic [10:0] E_MW     = 11'b0_000_0010000;
   localparam logic [10:0] E_MW_PC  = 11'b0_000_0010100;
   localparam logic [10:0] E_MW_ERR = 11'b0_000_0010101;
   localparam logic [10:0] E_WB     = 11'b0_000_1000100;
   localparam logic [10:0] E_BR     = 11'b0_000_0001100;
   localparam logic [10:0] E_PC     = 11'b0_000_0000100;
   localparam logic [10:0] E_ILL    = 11'b0_000_0000110;

   localparam logic [IW-1:0] I_ALU1 = {4'b0001, 6'b101101};
   localparam logic [IW-1:0] I_ALU3 = {4'b0011, 6'b010101};
   localparam logic [IW-1:0] I_LDR  = {4'b0100, 6'b110011};
   localparam logic [IW-1:0] I_STR  = {4'b0101, 6'b001110};
   localparam logic [IW-1:0] I_BR   = {4'b0110, 6'b111000};
   localparam logic [IW-1:0] I_BRZ  = {4'b0111, 6'b000111};
   localparam logic [IW-1:0] I_IL_A = {4'b1010, 6'b100001};
   localparam logic [IW-1:0] I_IL_C = {4'b1100, 6'b011110};
   localparam logic [IW-1:0] I_IL_F = {4'b1111, 6'b010010};

   typedef struct packed {
      logic          rn;
      logic          v;
      logic [IW-1:0] ins;
      logic          zf;
      logic          ack;
   } stim_t;

   logic clk = 1'b0;
   logic reset_n;
   int   checks = 0;
   int   errors = 0;

   stim_t        stim_q[$];
   logic [10:0]  exp_q[$];
   stim_t        s;
   logic [10:0]  e;
   logic [10:0]  obs;

   multicycle_ctrl_if #(.INSTR_W(IW), .ALU_OP_W(AW)) bus ();

`ifdef CTRL_PERF_CNT_EN
   logic [31:0] retired_cnt;
   logic [31:0] stall_cnt;
`endif

   multicycle_ctrl #(
      .INSTR_W    (IW),
      .OPC_W      (OW),
      .ALU_OP_W   (AW),
      .MEM_TIMEOUT(TO)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .bus        (bus)
`ifdef CTRL_PERF_CNT_EN
      ,
      .retired_cnt(retired_cnt),
      .stall_cnt  (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   assign obs = {bus.instr_ready, bus.alu_op, bus.reg_write, bus.mem_read,
                 bus.mem_write, bus.branch_taken, bus.pc_en, bus.illegal, bus.mem_err};

   // Queue one cycle of stimulus together with the outputs expected in that cycle.
   task automatic add(input logic rn, input logic v, input logic [IW-1:0] ins,
                      input logic zf, input logic ack, input logic [10:0] ex);
      stim_t t;
      t = '{rn: rn, v: v, ins: ins, zf: zf, ack: ack};
      stim_q.push_back(t);
      exp_q.push_back(ex);
   endtask

   // Four-cycle single-issue sequence: IDLE(accept), DECODE, EXEC, IDLE.
   task automatic seq4(input logic [IW-1:0] ins, input logic zf_exec,
                       input logic [10:0] ex_exec);
      add(1, 1, ins, ~zf_exec, 0, E_IDLE);
      add(1, 0, '0, ~zf_exec, 0, E_NONE);
      add(1, 0, '0, zf_exec, 0, ex_exec);
      add(1, 0, '0, ~zf_exec, 0, E_IDLE);
   endtask

   task automatic test_reset();
      add(0, 1, I_ALU1, 0, 0, E_IDLE);
      add(0, 1, I_ALU1, 0, 1, E_IDLE);
      add(1, 0, I_ALU1, 0, 0, E_IDLE);
      add(1, 0, '0, 0, 0, E_IDLE);
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         @(posedge clk); #1;
         {reset_n, bus.instr_valid, bus.instr, bus.zero_flag, bus.mem_ack} = s;
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL reset row%0d got %b want %b", 3 - stim_q.size(), obs, e);
         end
      end
   endtask

   task automatic test_alu();
      seq4(I_ALU1, 0, E_ALU1);
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         @(posedge clk); #1;
         {reset_n, bus.instr_valid, bus.instr, bus.zero_flag, bus.mem_ack} = s;
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL alu row%0d got %b want %b", 3 - stim_q.size(), obs, e);
         end
      end
   endtask

   task automatic test_back_to_back();
      add(1, 1, I_ALU3, 0, 0, E_IDLE);
      add(1, 1, I_BR,   0, 0, E_NONE);
      add(1, 1, I_BR,   0, 0, E_ALU3);
      add(1, 1, I_BR,   0, 0, E_IDLE);
      add(1, 0, '0,     0, 0, E_NONE);
      add(1, 0, '0,     0, 0, E_BR);
      add(1, 0, '0,     0, 0, E_IDLE);
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         @(posedge clk); #1;
         {reset_n, bus.instr_valid, bus.instr, bus.zero_flag, bus.mem_ack} = s;
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL b2b row%0d got %b want %b", 6 - stim_q.size(), obs, e);
         end
      end
   endtask

   task automatic test_mem();
      // LDR acked after three wait cycles.
      add(1, 1, I_LDR, 0, 0, E_IDLE);
      add(1, 0, '0, 0, 0, E_NONE);
      add(1, 0, '0, 0, 0, E_NONE);
      for (int i = 0; i < 3; i++) add(1, 0, '0, 0, 0, E_MR);
      add(1, 0, '0, 0, 1, E_MR);
      add(1, 0, '0, 0, 0, E_WB);
      add(1, 0, '0, 0, 0, E_IDLE);
      // STR with ack held outside MEM (ignored) and acked on second MEM cycle.
      add(1, 1, I_STR, 0, 1, E_IDLE);
      add(1, 0, '0, 0, 1, E_NONE);
      add(1, 0, '0, 0, 1, E_NONE);
      add(1, 0, '0, 0, 0, E_MW);
      add(1, 0, '0, 0, 1, E_MW_PC);
      add(1, 0, '0, 0, 0, E_IDLE);
      // STR timeout: four request cycles, abort on the last.
      add(1, 1, I_STR, 0, 0, E_IDLE);
      add(1, 0, '0, 0, 0, E_NONE);
      add(1, 0, '0, 0, 0, E_NONE);
      for (int i = 0; i < TO - 1; i++) add(1, 0, '0, 0, 0, E_MW);
      add(1, 0, '0, 0, 0, E_MW_ERR);
      add(1, 0, '0, 0, 0, E_IDLE);
      // LDR acked exactly at the timeout limit: ack wins.
      add(1, 1, I_LDR, 0, 0, E_IDLE);
      add(1, 0, '0, 0, 0, E_NONE);
      add(1, 0, '0, 0, 0, E_NONE);
      for (int i = 0; i < TO - 1; i++) add(1, 0, '0, 0, 0, E_MR);
      add(1, 0, '0, 0, 1, E_MR);
      add(1, 0, '0, 0, 0, E_WB);
      add(1, 0, '0, 0, 0, E_IDLE);
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         @(posedge clk); #1;
         {reset_n, bus.instr_valid, bus.instr, bus.zero_flag, bus.mem_ack} = s;
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL mem left%0d got %b want %b", stim_q.size(), obs, e);
         end
      end
   endtask

   task automatic test_branch();
      seq4(I_BRZ, 0, E_PC);
      seq4(I_BRZ, 1, E_BR);
      seq4(I_BR,  0, E_BR);
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         @(posedge clk); #1;
         {reset_n, bus.instr_valid, bus.instr, bus.zero_flag, bus.mem_ack} = s;
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL branch left%0d got %b want %b", stim_q.size(), obs, e);
         end
      end
   endtask

   task automatic test_illegal();
      seq4(I_IL_A, 1, E_ILL);
      seq4(I_IL_C, 1, E_ILL);
      seq4(I_IL_F, 1, E_ILL);
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         @(posedge clk); #1;
         {reset_n, bus.instr_valid, bus.instr, bus.zero_flag, bus.mem_ack} = s;
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL illegal left%0d got %b want %b", stim_q.size(), obs, e);
         end
      end
   endtask

   task automatic test_reset_mid_mem();
      add(1, 1, I_LDR, 0, 0, E_IDLE);
      add(1, 0, '0, 0, 0, E_NONE);
      add(1, 0, '0, 0, 0, E_NONE);
      add(1, 0, '0, 0, 0, E_MR);
      add(0, 0, '0, 0, 1, E_MR);
      add(1, 0, '0, 0, 0, E_IDLE);
      // Full-length timeout afterwards shows the wait counter was cleared.
      add(1, 1, I_STR, 0, 0, E_IDLE);
      add(1, 0, '0, 0, 0, E_NONE);
      add(1, 0, '0, 0, 0, E_NONE);
      for (int i = 0; i < TO - 1; i++) add(1, 0, '0, 0, 0, E_MW);
      add(1, 0, '0, 0, 0, E_MW_ERR);
      add(1, 0, '0, 0, 0, E_IDLE);
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         @(posedge clk); #1;
         {reset_n, bus.instr_valid, bus.instr, bus.zero_flag, bus.mem_ack} = s;
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL rst_mem left%0d got %b want %b", stim_q.size(), obs, e);
         end
      end
   endtask

`ifdef CTRL_PERF_CNT_EN
   task automatic test_perf();
      add(0, 0, '0, 0, 0, E_IDLE);
      add(1, 0, '0, 0, 0, E_IDLE);
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         @(posedge clk); #1;
         {reset_n, bus.instr_valid, bus.instr, bus.zero_flag, bus.mem_ack} = s;
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL perf_rst left%0d got %b want %b", stim_q.size(), obs, e);
         end
      end
      checks++;
      if (retired_cnt !== 32'd0 || stall_cnt !== 32'd0) begin
         errors++;
         $display("FAIL perf_zero got %0d/%0d want 0/0", retired_cnt, stall_cnt);
      end
      seq4(I_ALU1, 0, E_ALU1);
      seq4(I_BR,   0, E_BR);
      seq4(I_BRZ,  1, E_BR);
      add(1, 1, I_LDR, 0, 0, E_IDLE);
      add(1, 0, '0, 0, 0, E_NONE);
      add(1, 0, '0, 0, 0, E_NONE);
      for (int i = 0; i < 3; i++) add(1, 0, '0, 0, 0, E_MR);
      add(1, 0, '0, 0, 1, E_MR);
      add(1, 0, '0, 0, 0, E_WB);
      add(1, 0, '0, 0, 0, E_IDLE);
      add(1, 1, I_STR, 0, 0, E_IDLE);
      add(1, 0, '0, 0, 0, E_NONE);
      add(1, 0, '0, 0, 0, E_NONE);
      add(1, 0, '0, 0, 1, E_MW_PC);
      add(1, 0, '0, 0, 0, E_IDLE);
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         @(posedge clk); #1;
         {reset_n, bus.instr_valid, bus.instr, bus.zero_flag, bus.mem_ack} = s;
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL perf left%0d got %b want %b", stim_q.size(), obs, e);
         end
      end
      checks++;
      if (retired_cnt !== 32'd5 || stall_cnt !== 32'd3) begin
         errors++;
         $display("FAIL perf_cnt got %0d/%0d want 5/3", retired_cnt, stall_cnt);
      end
   endtask
`endif

   initial begin
      reset_n         = 1'b0;
      bus.instr_valid = 1'b0;
      bus.instr       = '0;
      bus.zero_flag   = 1'b0;
      bus.mem_ack     = 1'b0;
      test_reset();
      test_alu();
      test_back_to_back();
      test_mem();
      test_branch();
      test_illegal();
      test_reset_mid_mem();
`ifdef CTRL_PERF_CNT_EN
      test_perf();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
